// File: rtl/rotation_pkg.sv
// rtl/rotation_pkg.sv - shared types and helpers for the rotation slicer
package rotation_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    RUN
  } rot_state_t;

  localparam int NB_SLICES_DEFAULT = 128;

  // Index width for a slice count; never narrower than one bit
  function automatic int slice_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rotation_slicer_if.sv
// rtl/rotation_slicer_if.sv - hall input and slice/turn outputs of the rotation slicer
interface rotation_slicer_if
  import rotation_pkg::*;
#(
  parameter int NB_SLICES = NB_SLICES_DEFAULT,
  parameter int CNT_W     = 24
);

  localparam int SLICE_W = slice_w(NB_SLICES);

  logic               hall_in;
  logic [SLICE_W-1:0] slice_idx;
  logic               slice_strobe;
  logic               turn_strobe;
  logic [CNT_W-1:0]   period;
  logic               locked;

  modport master (
    output hall_in,
    input  slice_idx, slice_strobe, turn_strobe, period, locked
  );

  modport slave (
    input  hall_in,
    output slice_idx, slice_strobe, turn_strobe, period, locked
  );

endinterface

// File: rtl/slice_ticker.sv
// rtl/slice_ticker.sv - splits a turn of `period` cycles into NB_SLICES slices
// using an error accumulator, so non-divisible periods still give NB_SLICES slices.
module slice_ticker
  import rotation_pkg::*;
#(
  parameter  int NB_SLICES = NB_SLICES_DEFAULT,
  parameter  int CNT_W     = 24,
  localparam int SLICE_W   = slice_w(NB_SLICES)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               clear,
  input  logic               enable,
  input  logic [CNT_W-1:0]   period,
  output logic [SLICE_W-1:0] slice_idx,
  output logic               slice_strobe
);

  localparam int                 ACC_W   = CNT_W + SLICE_W + 1;
  localparam logic [ACC_W-1:0]   STEP    = ACC_W'(NB_SLICES);
  localparam logic [SLICE_W-1:0] IDX_MAX = SLICE_W'(NB_SLICES - 1);
  localparam logic [SLICE_W-1:0] IDX_ONE = SLICE_W'(1);

  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   nxt;
  logic [ACC_W-1:0]   per_ext;
  logic [SLICE_W-1:0] idx_q, idx_d;
  logic               strobe_q, strobe_d;

  assign per_ext = ACC_W'(period);

  // A clear while enabled is the turn boundary itself: it restarts at slice 0 and strobes once
  always_comb begin
    acc_d    = acc_q;
    idx_d    = idx_q;
    strobe_d = 1'b0;
    nxt      = acc_q + STEP;
    if (clear) begin
      acc_d    = '0;
      idx_d    = '0;
      strobe_d = enable;
    end else if (enable && (idx_q != IDX_MAX)) begin
      if (nxt >= per_ext) begin
        acc_d    = nxt - per_ext;
        idx_d    = idx_q + IDX_ONE;
        strobe_d = 1'b1;
      end else begin
        acc_d = nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_q    <= '0;
      idx_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
    end
  end

  assign slice_idx    = idx_q;
  assign slice_strobe = strobe_q;

endmodule

// File: rtl/rotation_slicer.sv
// rtl/rotation_slicer.sv - measures the hall-pulse rotation period, tracks lock
// and drives the slice ticker from the previous turn's period.
module rotation_slicer
  import rotation_pkg::*;
#(
  parameter int NB_SLICES  = NB_SLICES_DEFAULT,
  parameter int CNT_W      = 24,
  parameter int MIN_PERIOD = 1000,
  parameter int TIMEOUT    = 16_000_000
) (
  input logic               clk,
  input logic               nrst,
  rotation_slicer_if.slave  bus
);

  if (MIN_PERIOD < NB_SLICES) begin : g_bad_min_period
    $error("rotation_slicer: MIN_PERIOD must be >= NB_SLICES");
  end
  if (64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_timeout
    $error("rotation_slicer: TIMEOUT must be < 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  rot_state_t       state_q, state_d;
  logic             hall_prev_q, hall_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             turn_strobe_q, turn_strobe_d;
  logic             locked_q, locked_d;
  logic             fall, accept;
  logic             tick_enable, tick_clear;

  always_comb begin
    hall_prev_d   = bus.hall_in;
    fall          = hall_prev_q & ~bus.hall_in;
    // Falls closer than MIN_PERIOD to the last accepted one are bounce or noise
    accept        = fall && ((state_q == IDLE) || (cnt_q >= MIN_P));
    cnt_d         = accept ? ONE : ((cnt_q < TMO) ? cnt_q + ONE : cnt_q);
    state_d       = state_q;
    period_d      = period_q;
    turn_strobe_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = MEASURE;
      end
      MEASURE: begin
        if (accept) begin
          state_d  = RUN;
          period_d = cnt_q;
        end else if (cnt_q == TMO) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (accept) begin
          period_d      = cnt_q;
          turn_strobe_d = 1'b1;
        end else if (cnt_q == TMO) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    locked_d    = (state_d == RUN);
    tick_enable = (state_d == RUN);
    tick_clear  = accept | ~tick_enable;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= IDLE;
      hall_prev_q   <= 1'b1;
      cnt_q         <= '0;
      period_q      <= '0;
      turn_strobe_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      hall_prev_q   <= hall_prev_d;
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      turn_strobe_q <= turn_strobe_d;
      locked_q      <= locked_d;
    end
  end

  slice_ticker #(
    .NB_SLICES (NB_SLICES),
    .CNT_W     (CNT_W)
  ) u_ticker (
    .clk          (clk),
    .nrst         (nrst),
    .clear        (tick_clear),
    .enable       (tick_enable),
    .period       (period_q),
    .slice_idx    (bus.slice_idx),
    .slice_strobe (bus.slice_strobe)
  );

  assign bus.turn_strobe = turn_strobe_q;
  assign bus.period      = period_q;
  assign bus.locked      = locked_q;

endmodule

// File: tb/tb_rotation_slicer.sv
// tb/tb_rotation_slicer.sv - directed bench for rotation_slicer (NB_SLICES=8, CNT_W=12)
module tb_rotation_slicer;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic        rec_ss  [0:2047];
  logic        rec_ts  [0:2047];
  logic        rec_lk  [0:2047];
  logic [2:0]  rec_idx [0:2047];
  logic [11:0] rec_per [0:2047];

  always #5 clk = ~clk;

  rotation_slicer_if #(.NB_SLICES(8), .CNT_W(12)) bus ();

  rotation_slicer #(
    .NB_SLICES  (8),
    .CNT_W      (12),
    .MIN_PERIOD (16),
    .TIMEOUT    (1000)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One turn of len cycles: the fall lands on record 0, optional low glitch at gat for glen cycles
  task automatic turn(input int len, input int gat, input int glen);
    for (int j = 0; j < len; j++) begin
      bus.hall_in = ((j < 4) || ((j >= gat) && (j < gat + glen))) ? 1'b0 : 1'b1;
      tick();
      rec_ss[j]  = bus.slice_strobe;
      rec_ts[j]  = bus.turn_strobe;
      rec_lk[j]  = bus.locked;
      rec_idx[j] = bus.slice_idx;
      rec_per[j] = bus.period;
    end
  endtask

  task automatic test_reset();
    bus.hall_in = 1'b1;
    nrst = 1'b0;
    repeat (3) tick();
    nrst = 1'b1;
    repeat (3) tick();
    checks++; if (bus.slice_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", bus.slice_idx); end
    checks++; if (bus.slice_strobe !== 1'b0) begin errors++; $display("FAIL reset_ss: got %0b want 0", bus.slice_strobe); end
    checks++; if (bus.turn_strobe !== 1'b0) begin errors++; $display("FAIL reset_ts: got %0b want 0", bus.turn_strobe); end
    checks++; if (bus.period !== 12'd0) begin errors++; $display("FAIL reset_period: got %0d want 0", bus.period); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b want 0", bus.locked); end
  endtask

  task automatic test_lock_80();
    int bad = 0;
    int first = -1;
    turn(80, 0, 0);
    checks++; if (rec_lk[0] !== 1'b0 || rec_ss[0] !== 1'b0) begin errors++; $display("FAIL lock80_first_edge: locked=%0b ss=%0b want 0 0", rec_lk[0], rec_ss[0]); end
    turn(80, 0, 0);
    checks++; if (rec_lk[0] !== 1'b1) begin errors++; $display("FAIL lock80_locked: got %0b want 1", rec_lk[0]); end
    checks++; if (rec_per[0] !== 12'd80) begin errors++; $display("FAIL lock80_period: got %0d want 80", rec_per[0]); end
    checks++; if (rec_ss[0] !== 1'b1 || rec_ts[0] !== 1'b0) begin errors++; $display("FAIL lock80_entry_strobes: ss=%0b ts=%0b want 1 0", rec_ss[0], rec_ts[0]); end
    turn(80, 0, 0);
    for (int j = 0; j < 80; j++) begin
      if ((rec_ss[j] !== ((j % 10) == 0)) || (rec_ts[j] !== (j == 0)) ||
          (((j % 10) == 0) && (rec_idx[j] !== 3'(j / 10)))) begin
        bad++;
        if (first < 0) first = j;
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL lock80_slices: got %0d bad cycles (first %0d) want 0", bad, first); end
  endtask

  task automatic test_period_83();
    int pos83 [8] = '{0, 11, 21, 32, 42, 52, 63, 73};
    int n = 0;
    int bad = 0;
    turn(83, 0, 0);
    turn(83, 0, 0);
    checks++; if (rec_per[0] !== 12'd83) begin errors++; $display("FAIL p83_period: got %0d want 83", rec_per[0]); end
    for (int j = 0; j < 83; j++) begin
      if (rec_ss[j] === 1'b1) begin
        if (n < 8) begin
          if ((j != pos83[n]) || (rec_idx[j] !== 3'(n))) bad++;
        end
        n++;
      end
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL p83_count: got %0d want 8", n); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL p83_positions: got %0d misplaced want 0", bad); end
    checks++; if (rec_idx[82] !== 3'd7) begin errors++; $display("FAIL p83_last_idx: got %0d want 7", rec_idx[82]); end
  endtask

  task automatic test_glitch();
    int nts = 0;
    int bad = 0;
    turn(80, 0, 0);
    turn(80, 10, 5);
    for (int j = 0; j < 80; j++) begin
      if (rec_ts[j] === 1'b1) nts++;
      if ((rec_ss[j] !== ((j % 10) == 0)) || (rec_lk[j] !== 1'b1)) bad++;
    end
    checks++; if (nts !== 1) begin errors++; $display("FAIL glitch_turn_strobes: got %0d want 1", nts); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL glitch_slices: got %0d bad cycles want 0", bad); end
    checks++; if (rec_per[79] !== 12'd80) begin errors++; $display("FAIL glitch_period_hold: got %0d want 80", rec_per[79]); end
    turn(80, 0, 0);
    checks++; if (rec_per[0] !== 12'd80 || rec_ts[0] !== 1'b1) begin errors++; $display("FAIL glitch_next_edge: period=%0d ts=%0b want 80 1", rec_per[0], rec_ts[0]); end
  endtask

  task automatic test_timeout();
    int n = 0;
    turn(1010, 0, 0);
    for (int j = 71; j < 1010; j++) if (rec_ss[j] === 1'b1 || rec_ts[j] === 1'b1) n++;
    checks++; if (n !== 0) begin errors++; $display("FAIL tmo_no_strobes: got %0d strobes want 0", n); end
    checks++; if (rec_lk[999] !== 1'b1 || rec_idx[999] !== 3'd7) begin errors++; $display("FAIL tmo_before: locked=%0b idx=%0d want 1 7", rec_lk[999], rec_idx[999]); end
    checks++; if (rec_lk[1000] !== 1'b0 || rec_idx[1000] !== 3'd0) begin errors++; $display("FAIL tmo_unlock: locked=%0b idx=%0d want 0 0", rec_lk[1000], rec_idx[1000]); end
    turn(80, 0, 0);
    checks++; if (rec_lk[0] !== 1'b0 || rec_ss[0] !== 1'b0 || rec_ts[0] !== 1'b0) begin errors++; $display("FAIL tmo_rearm: locked=%0b ss=%0b ts=%0b want 0 0 0", rec_lk[0], rec_ss[0], rec_ts[0]); end
    turn(80, 0, 0);
    checks++; if (rec_lk[0] !== 1'b1) begin errors++; $display("FAIL tmo_relock: got %0b want 1", rec_lk[0]); end
  endtask

  task automatic test_stretch();
    int n = 0;
    int bad = 0;
    turn(120, 0, 0);
    for (int j = 71; j < 120; j++) if (rec_ss[j] === 1'b1) n++;
    checks++; if (n !== 0 || rec_idx[119] !== 3'd7) begin errors++; $display("FAIL stretch_saturate: strobes=%0d idx=%0d want 0 7", n, rec_idx[119]); end
    turn(120, 0, 0);
    checks++; if (rec_per[0] !== 12'd120 || rec_idx[0] !== 3'd0 || rec_ss[0] !== 1'b1) begin errors++; $display("FAIL stretch_edge: period=%0d idx=%0d ss=%0b want 120 0 1", rec_per[0], rec_idx[0], rec_ss[0]); end
    for (int j = 0; j < 120; j++) begin
      if ((rec_ss[j] !== ((j % 15) == 0)) || (rec_ts[j] !== (j == 0)) ||
          (((j % 15) == 0) && (rec_idx[j] !== 3'(j / 15)))) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stretch_spacing15: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_reset_mid_turn();
    logic found = 1'b0;
    bus.hall_in = 1'b0;
    tick();
    for (int j = 1; (j < 200) && !found; j++) begin
      bus.hall_in = (j < 4) ? 1'b0 : 1'b1;
      tick();
      if (bus.slice_idx === 3'd4) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL mid_reach_idx4: got %0b want 1", found); end
    #2 nrst = 1'b0;
    #1;
    checks++; if (bus.slice_idx !== 3'd0 || bus.locked !== 1'b0) begin errors++; $display("FAIL mid_async_idx_lock: idx=%0d locked=%0b want 0 0", bus.slice_idx, bus.locked); end
    checks++; if (bus.period !== 12'd0) begin errors++; $display("FAIL mid_async_period: got %0d want 0", bus.period); end
    checks++; if (bus.slice_strobe !== 1'b0 || bus.turn_strobe !== 1'b0) begin errors++; $display("FAIL mid_async_strobes: ss=%0b ts=%0b want 0 0", bus.slice_strobe, bus.turn_strobe); end
    repeat (2) tick();
    nrst = 1'b1;
    repeat (3) tick();
    turn(80, 0, 0);
    checks++; if (rec_lk[0] !== 1'b0 || rec_per[0] !== 12'd0) begin errors++; $display("FAIL mid_first_edge: locked=%0b period=%0d want 0 0", rec_lk[0], rec_per[0]); end
    turn(80, 0, 0);
    checks++; if (rec_lk[0] !== 1'b1 || rec_per[0] !== 12'd80) begin errors++; $display("FAIL mid_relock: locked=%0b period=%0d want 1 80", rec_lk[0], rec_per[0]); end
  endtask

  initial begin
    bus.hall_in = 1'b1;
    test_reset();
    test_lock_80();
    test_period_83();
    test_glitch();
    test_timeout();
    test_stretch();
    test_reset_mid_turn();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
